// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory stage and the data memory (req/gnt/rvalid).
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: drives the data bus, forms byte enables, extends loads, stalls upstream.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses complete with bus_err and no bus request.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         fn3,
  input  logic [31:0]        alu_out,
  input  logic [31:0]        rs2_data,
  mem_access_unit_if.master  dmem,
  output logic [31:0]        load_data,
  output logic               done,
  output logic               bus_err,
  output logic               stall
);

  // state | meaning
  // IDLE  | waiting for a load/store in the stage
  // REQ   | dmem_req held until dmem_gnt or timeout
  // WAIT  | read granted, waiting for dmem_rvalid or timeout
  // DONE  | one-cycle completion pulse, bus_err qualifies it
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic               err_q, err_d;
  logic [2:0]         fn3_q, fn3_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        load_data_q, load_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               access;
  logic               fn3_legal;
  logic               misalign;
  logic [3:0]         be_new;
  logic [31:0]        wdata_new;
  logic [31:0]        rsh_b;
  logic [31:0]        rsh_h;
  logic [31:0]        load_ext;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout;

  assign access  = in_valid & (mem_read | mem_write);
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign timeout = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // A simultaneous read/write request is handled as a read, so stores are mem_write & ~mem_read.
  always_comb begin
    fn3_legal = 1'b0;
    case (fn3)
      3'b000, 3'b001, 3'b010: fn3_legal = 1'b1;
      3'b100, 3'b101:         fn3_legal = mem_read;
      default:                fn3_legal = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((fn3[1:0] == 2'b01) & alu_out[0]) |
                    ((fn3[1:0] == 2'b10) & (alu_out[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = rs2_data;
    case (fn3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << alu_out[1:0];
        wdata_new = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << {alu_out[1], 1'b0};
        wdata_new = {2{rs2_data[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = rs2_data;
      end
    endcase
  end

  assign rsh_b = dmem.dmem_rdata >> {addr_q[1:0], 3'b000};
  assign rsh_h = dmem.dmem_rdata >> {addr_q[1], 4'b0000};

  always_comb begin
    load_ext = dmem.dmem_rdata;
    case (fn3_q)
      3'b000:  load_ext = {{24{rsh_b[7]}}, rsh_b[7:0]};
      3'b100:  load_ext = {24'h000000, rsh_b[7:0]};
      3'b001:  load_ext = {{16{rsh_h[15]}}, rsh_h[15:0]};
      3'b101:  load_ext = {16'h0000, rsh_h[15:0]};
      default: load_ext = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    err_d       = err_q;
    fn3_d       = fn3_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          addr_d      = alu_out;
          fn3_d       = fn3;
          we_d        = mem_write & ~mem_read;
          be_d        = be_new;
          wdata_d     = wdata_new;
          load_data_d = '0;
          if (!fn3_legal || misalign) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (dmem.dmem_gnt) begin
          state_d = we_q ? DONE : WAIT;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (dmem.dmem_rvalid) begin
          load_data_d = load_ext;
          state_d     = DONE;
        end else if (timeout) begin
          err_d       = 1'b1;
          load_data_d = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      fn3_q       <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      err_q       <= err_d;
      fn3_q       <= fn3_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dmem.dmem_req   = (state_q == REQ);
  assign dmem.dmem_we    = (state_q == REQ) & we_q;
  assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  assign done      = (state_q == DONE);
  assign bus_err   = done & err_q;
  assign load_data = load_data_q;
  assign stall     = ((state_q == IDLE) & access) | (state_q == REQ) | (state_q == WAIT);

endmodule
